// File: rtl/sha256_msg_sched.sv
// rtl/sha256_msg_sched.sv - streaming SHA-256 message-schedule generator
//
// Accepts one 512-bit block as 16 serial 32-bit words (word 0 first) and
// emits the expanded schedule words w[0..ROUNDS-1] in round order.
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset (control state only)
//   clear      synchronous abort back to LOAD with an empty window
//   in_valid   in_word holds the next block word
//   in_ready   a block word is accepted this cycle (LOAD only)
//   in_word    block word
//   out_valid  out_w/out_t hold a schedule word (EMIT only)
//   out_ready  downstream accepts the current word
//   out_w      schedule word w[out_t], forced to 0 when out_valid is low
//   out_t      round index of out_w
//   out_last   out_valid and out_t == ROUNDS-1
//   busy       partially loaded block or emitting
module sha256_msg_sched #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_w,
  output logic [5:0]  out_t,
  output logic        out_last,
  output logic        busy
);

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [4:0]  lcnt, lcnt_nx;
  logic [5:0]  t, t_nx;
  logic        load_we;
  logic        shift_en;
  logic [31:0] win [16];
  logic [31:0] new_w;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // win[0] is w[t]; win[1], win[9], win[14] are w[t+1], w[t+9], w[t+14],
  // so this produces w[t+16] to be appended at the young end.
  assign new_w = win[0] + ssig0(win[1]) + win[9] + ssig1(win[14]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      lcnt  <= '0;
      t     <= '0;
    end else begin
      state <= state_nx;
      lcnt  <= lcnt_nx;
      t     <= t_nx;
    end
  end

  always_comb begin
    state_nx = state;
    lcnt_nx  = lcnt;
    t_nx     = t;
    load_we  = 1'b0;
    shift_en = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        if (in_valid) begin
          load_we = 1'b1;
          if (lcnt == 5'd15) begin
            state_nx = ST_EMIT;
            lcnt_nx  = '0;
            t_nx     = '0;
          end else begin
            lcnt_nx = lcnt + 5'd1;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          shift_en = 1'b1;
          if (t == LAST_T) begin
            state_nx = ST_LOAD;
            t_nx     = '0;
          end else begin
            t_nx = t + 6'd1;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
    // Abort wins over any handshake presented in the same cycle.
    if (clear) begin
      state_nx = ST_LOAD;
      lcnt_nx  = '0;
      t_nx     = '0;
      load_we  = 1'b0;
      shift_en = 1'b0;
    end
  end

  // Window data carries no reset; it is only meaningful during EMIT.
  always_ff @(posedge clk) begin
    if (load_we) begin
      win[lcnt[3:0]] <= in_word;
    end else if (shift_en) begin
      for (int i = 0; i < 15; i++) begin
        win[i] <= win[i+1];
      end
      win[15] <= new_w;
    end
  end

  assign in_ready  = (state == ST_LOAD);
  assign out_valid = (state == ST_EMIT);
  assign out_w     = out_valid ? win[0] : 32'd0;
  assign out_t     = t;
  assign out_last  = out_valid && (t == LAST_T);
  assign busy      = ((state == ST_LOAD) && (lcnt != 5'd0)) || (state == ST_EMIT);

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb/tb_sha256_msg_sched.sv - self-checking bench for sha256_msg_sched
module tb_sha256_msg_sched;

  localparam int ROUNDS = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_w;
  logic [5:0]  out_t;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] w;
    logic [5:0]  t;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] blk  [16];
  logic [31:0] wexp [64];
  logic [31:0] got  [64];
  int          ncyc;

  always #5 clk = ~clk;

  sha256_msg_sched #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_w     (out_w),
    .out_t     (out_t),
    .out_last  (out_last),
    .busy      (busy)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Textbook schedule recurrence, filled into the scoreboard queue.
  task automatic push_model();
    for (int i = 0; i < 16; i++) wexp[i] = blk[i];
    for (int i = 16; i < 64; i++)
      wexp[i] = sig1(wexp[i-2]) + wexp[i-7] + sig0(wexp[i-15]) + wexp[i-16];
    for (int i = 0; i < ROUNDS; i++)
      sb.push_back('{w: wexp[i], t: 6'(i), last: (i == ROUNDS - 1)});
  endtask

  task automatic run_block(input int gap_pct, input int stall_pct, input int clear_at,
                           output int cycles);
    int   i;
    int   n;
    int   cyc;
    bit   hs;
    exp_t e;
    push_model();
    i   = 0;
    n   = 0;
    cyc = 0;
    while (i < 16 && cyc < 2000) begin
      in_word  = blk[i];
      in_valid = ($urandom_range(99) >= gap_pct);
      hs       = in_valid && in_ready;
      chk("excl_load", 32'(in_ready & out_valid), 32'd0);
      if (in_ready && i > 0) chk("busy_load", 32'(busy), 32'd1);
      step();
      cyc++;
      if (hs) i++;
    end
    in_valid = 1'b0;
    if (i < 16) chk("load_timeout", 32'(i), 32'd16);
    chk("latency_valid", 32'(out_valid), 32'd1);
    while (n < ROUNDS && cyc < 4000) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      if (clear_at == n && out_valid) begin
        clear     = 1'b1;
        out_ready = 1'b1;
        step();
        clear     = 1'b0;
        out_ready = 1'b0;
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        sb.delete();
        cycles = cyc;
        return;
      end
      chk("excl_emit", 32'(in_ready & out_valid), 32'd0);
      if (!out_valid) chk("emit_valid", 32'(out_valid), 32'd1);
      hs = out_valid && out_ready;
      if (hs) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("out_w", out_w, e.w);
          chk("out_t", 32'(out_t), 32'(e.t));
          chk("out_last", 32'(out_last), 32'(e.last));
        end
        got[n] = out_w;
        n++;
      end
      step();
      cyc++;
    end
    out_ready = 1'b0;
    if (n < ROUNDS) chk("emit_timeout", 32'(n), 32'(ROUNDS));
    chk("reload_in_ready", 32'(in_ready), 32'd1);
    chk("reload_out_valid", 32'(out_valid), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    cycles = cyc;
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) blk[i] = $urandom();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_word   = 32'd0;

    // Reset held with random inputs.
    for (int k = 0; k < 4; k++) begin
      in_valid  = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      clear     = 1'($urandom_range(1));
      in_word   = $urandom();
      step();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_w", out_w, 32'd0);
      chk("rst_out_t", 32'(out_t), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear     = 1'b0;
    reset_n   = 1'b1;
    chk("rel_in_ready_c1", 32'(in_ready), 32'd0);
    step();
    chk("rel_in_ready_c2", 32'(in_ready), 32'd1);
    chk("rel_busy", 32'(busy), 32'd0);

    // "abc" block at full throughput.
    set_abc();
    run_block(0, 0, -1, ncyc);
    chk("abc_cycles", 32'(ncyc), 32'd80);
    chk("abc_w0", got[0], 32'h61626380);
    chk("abc_w1", got[1], 32'h00000000);
    chk("abc_w15", got[15], 32'h00000018);
    chk("abc_w16", got[16], 32'h61626380);
    chk("abc_w17", got[17], 32'h000F0000);
    chk("abc_w18", got[18], 32'h7DA86405);

    // All-zero block.
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    run_block(0, 0, -1, ncyc);
    chk("zero_w63", got[63], 32'd0);

    // Same "abc" block with input gaps and output backpressure.
    set_abc();
    run_block(30, 45, -1, ncyc);
    chk("bp_w18", got[18], 32'h7DA86405);

    // Abort at out_t = 20, then a fresh block from w[0].
    set_random();
    run_block(0, 20, 20, ncyc);
    set_random();
    run_block(10, 10, -1, ncyc);

    // Reset mid-load discards progress.
    set_random();
    in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_word = blk[k];
      step();
    end
    in_valid = 1'b0;
    reset_n  = 1'b0;
    step();
    chk("midrst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    run_block(0, 0, -1, ncyc);

    // Header block followed immediately by nonce block (nonce = 5).
    set_random();
    run_block(0, 0, -1, ncyc);
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = $urandom();
    blk[1]  = $urandom();
    blk[2]  = $urandom();
    blk[3]  = 32'h00000005;
    blk[4]  = 32'h80000000;
    blk[15] = 32'h00000280;
    run_block(0, 0, -1, ncyc);
    chk("nonce_w3", got[3], 32'h00000005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_msg_sched.md
# sha256_msg_sched

Streaming SHA-256 message-schedule generator for the bitcoin hashing datapath. It accepts one 512-bit block as 16 serial 32-bit words. It then emits the 64 expanded schedule words w[0..63] in round order to the downstream compression-round engine, using a valid/ready handshake. It sits between the memory-fetch/padding logic and the round engine, and is reused for all three blocks of a bitcoin hash: header block 1, the nonce block, and the 256-bit re-hash block.

## Interface
- ROUNDS, 64: number of schedule words emitted per block; legal range 16..64.
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort; returns to LOAD with word count 0.
- in_valid  in  1  in_word holds the next block word.
- in_ready  out  1  block accepts a word this cycle.
- in_word  in  32  block word, word 0 (MSW of block) first.
- out_valid  out  1  out_w/out_t hold a valid schedule word.
- out_ready  in  1  downstream accepts the current word.
- out_w  out  32  schedule word w[out_t].
- out_t  out  6  round index of out_w.
- out_last  out  1  high with out_valid when out_t == ROUNDS-1.
- busy  out  1  high in LOAD (count > 0) or EMIT.

## Operation
- Storage: 16-entry × 32-bit window win[0..15]. win[0] is the oldest word. Load counter lcnt[4:0]. Round counter t[5:0].
- States: IDLE → LOAD → EMIT → LOAD.
- IDLE: entered on reset. Moves to LOAD unconditionally on the next edge.
- LOAD: in_ready = 1. Each in_valid&in_ready handshake writes win[lcnt] and increments lcnt. When the handshake with lcnt == 15 occurs: go to EMIT, set t = 0, clear lcnt.
- EMIT: out_valid = 1, out_w = win[0], out_t = t. On each out_valid&out_ready handshake:
  - all entries shift down (win[i] ← win[i+1]);
  - win[15] ← win[0] + σ0(win[1]) + win[9] + σ1(win[14]), mod 2^32;
  - t increments.
  - This yields w[t+16] = w[t] + σ0(w[t+1]) + w[t+9] + σ1(w[t+14]).
- σ0(x) = rotr(x,7) ^ rotr(x,18) ^ (x>>3). σ1(x) = rotr(x,17) ^ rotr(x,19) ^ (x>>10). All adds truncate to 32 bits.
- A handshake with t == ROUNDS-1 returns to LOAD. lcnt is already 0 at that point.
- clear has priority over all handshakes in the same cycle. Any handshake in that cycle is ignored; no word is consumed or emitted.
- win contents are not reset and are don't-care outside EMIT. Only the control regs are reset.

## Timing
- Reset values, applied asynchronously while reset_n = 0:
  - state = IDLE; lcnt = 0; t = 0.
  - in_ready = 0, out_valid = 0, out_last = 0, busy = 0.
  - out_t = 0; out_w = 0 (out_w is masked to 0 when out_valid = 0).
- First in_ready = 1 occurs in the second cycle after reset_n deasserts.
- Latency: if the 16th word is accepted at edge N, out_valid = 1 with w[0] in the cycle after edge N.
- Throughput with in_valid and out_ready held high: one word per cycle. A block takes 16 load + ROUNDS emit cycles; in_ready re-asserts the cycle after the last emit handshake.
- Backpressure: while out_valid = 1 and out_ready = 0, out_w, out_t and out_last stay stable.
- in_ready and out_valid are never high in the same cycle.
- in_valid outside LOAD is ignored. out_ready outside EMIT is ignored.
- Reset mid-block: all progress is discarded. Next block loads from word 0.
- clear mid-LOAD or mid-EMIT: the next cycle is LOAD with lcnt = 0 and out_valid = 0.

## Test plan
- Reset check: hold reset_n low with random inputs. Required: in_ready = out_valid = busy = 0. In the second cycle after release, in_ready = 1.
- "abc" padded block, with ready/valid always high:
  - load w0 = 0x61626380, w1..w14 = 0, w15 = 0x00000018;
  - required: out_w sequence begins 0x61626380, 0, …, 0x18, then w16 = 0x61626380, w17 = 0x000F0000, w18 = 0x7DA86405;
  - all 64 words match the software model; out_last at out_t = 63; 80 cycles total.
- All-zero block: required 64 words of 0x00000000, out_t runs 0..63, followed by in_ready = 1.
- Random backpressure: out_ready toggled pseudo-randomly, in_valid with random gaps. Required: the emitted sequence is identical to the no-stall run, with no duplicate or skipped out_t.
- clear asserted at out_t = 20 together with out_ready = 1. Required: no handshake counted; the next cycle has in_ready = 1 and out_valid = 0; a fresh block then emits correctly from w[0].
- Two back-to-back blocks (header block, then nonce block 0x…, nonce = 5). Required: the second block's words match the model; no carry-over from the first block's window.
